// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: command, ALU-drive and result channels of the ALU
// operation sequencer.
// The slave modport is the sequencer's view. The master modport is the view of
// the environment: the command source, the ALU and the result sink.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 32
);
    // Command channel
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;

    // ALU drive and return
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_s0;
    logic             alu_s1;
    logic             alu_s2;
    logic [WIDTH-1:0] alu_f;

    // Result channel and status
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [2:0]       res_op;
    logic             busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_f, res_ready,
        output cmd_ready, alu_a, alu_b, alu_s0, alu_s1, alu_s2,
               res_valid, res_data, res_op, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_f, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_s0, alu_s1, alu_s2,
               res_valid, res_data, res_op, busy
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: sequential front-end for a combinational 8-op ALU.
// Operation:
//   - Latch a command and drive it to the ALU.
//   - Wait a settle time that depends on the op group.
//   - Register F and hand it downstream over valid/ready.
// Optional feature macro ALU_SEQ_OP_COUNT_EN:
//   - Adds op_count[15:0], a wrapping count of result handshakes.
module alu_op_sequencer #(
    parameter int WIDTH    = 32,
    parameter int ADD_WAIT = 1,
    parameter int MUL_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef ALU_SEQ_OP_COUNT_EN
    output logic [15:0]       op_count,
`endif
    alu_op_sequencer_if.slave bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    localparam logic [3:0] LP_ADD_WAIT = 4'(ADD_WAIT);
    localparam logic [3:0] LP_MUL_WAIT = 4'(MUL_WAIT);

    logic [1:0]       r_state;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_op;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_data;
    logic [2:0]       r_res_op;

    logic             w_accept;
    logic             w_capture;
    logic             w_res_done;
    logic [3:0]       w_wait_load;

    assign w_accept    = (r_state == S_IDLE) && bus.cmd_valid;
    assign w_capture   = (r_state == S_SETTLE) && (r_cnt == 4'd1);
    assign w_res_done  = (r_state == S_HOLD) && bus.res_ready;
    // The multiply group (op[2]=1) needs the longer settle time.
    assign w_wait_load = bus.cmd_op[2] ? LP_MUL_WAIT : LP_ADD_WAIT;

    // State register and settle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= w_wait_load;
                    end
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // ALU operands and opcode change only when a command is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= 3'd0;
        end else if (w_accept) begin
            r_alu_a  <= bus.cmd_a;
            r_alu_b  <= bus.cmd_b;
            r_alu_op <= bus.cmd_op;
        end
    end

    // Result register: capture F at the end of the settle time, then hold until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_op    <= 3'd0;
        end else if (w_capture) begin
            r_res_valid <= 1'b1;
            r_res_data  <= bus.alu_f;
            r_res_op    <= r_alu_op;
        end else if (w_res_done) begin
            r_res_valid <= 1'b0;
        end
    end

`ifdef ALU_SEQ_OP_COUNT_EN
    logic [15:0] r_op_count;

    // Count completed result handshakes, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= 16'd0;
        end else if (r_res_valid && bus.res_ready) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`endif

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_s0    = r_alu_op[0];
    assign bus.alu_s1    = r_alu_op[1];
    assign bus.alu_s2    = r_alu_op[2];
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_op    = r_res_op;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed test of alu_op_sequencer driving a 32-bit ALU model.
// Define ALU_SEQ_OP_COUNT_EN to also exercise the op_count output.
module tb_alu_op_sequencer;

    localparam int WIDTH    = 32;
    localparam int ADD_WAIT = 1;
    localparam int MUL_WAIT = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_op_sequencer_if #(.WIDTH(WIDTH)) bus ();

`ifdef ALU_SEQ_OP_COUNT_EN
    logic [15:0] op_count;
`endif

    alu_op_sequencer #(
        .WIDTH   (WIDTH),
        .ADD_WAIT(ADD_WAIT),
        .MUL_WAIT(MUL_WAIT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef ALU_SEQ_OP_COUNT_EN
        .op_count(op_count),
`endif
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Combinational 8-op ALU: add, inc, sub, dec, then the multiply group.
    always_comb begin
        case ({bus.alu_s2, bus.alu_s1, bus.alu_s0})
            3'b000:  bus.alu_f = bus.alu_a + bus.alu_b;
            3'b001:  bus.alu_f = bus.alu_a + 32'd1;
            3'b010:  bus.alu_f = bus.alu_a - bus.alu_b;
            3'b011:  bus.alu_f = bus.alu_a - 32'd1;
            default: bus.alu_f = bus.alu_a * bus.alu_b;
        endcase
    end

    // Settle-time parameters must fit the 4-bit counter.
    initial begin
        assert (ADD_WAIT >= 1 && ADD_WAIT <= 15 && MUL_WAIT >= 1 && MUL_WAIT <= 15)
            else $fatal(1, "FAIL param_range ADD_WAIT=%0d MUL_WAIT=%0d", ADD_WAIT, MUL_WAIT);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one command with res_ready=1.
    // Check the operand latch, the latency and the result, then the return to IDLE.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        @(negedge clk);
        check_eq({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check_eq({tag, "_alu_a"}, bus.alu_a, a);
        check_eq({tag, "_alu_b"}, bus.alu_b, b);
        check_eq({tag, "_alu_s"}, 32'({bus.alu_s2, bus.alu_s1, bus.alu_s0}), 32'(op));
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
        for (int i = 0; i < lat; i++) begin
            check_eq({tag, "_early_valid"}, 32'(bus.res_valid), 32'd0);
            @(negedge clk);
        end
        check_eq({tag, "_res_valid"}, 32'(bus.res_valid), 32'd1);
        check_eq({tag, "_res_data"}, bus.res_data, exp);
        check_eq({tag, "_res_op"}, 32'(bus.res_op), 32'(op));
        $display("op %s: op=%b a=0x%08h b=0x%08h res=0x%08h exp=0x%08h lat=%0d",
                 tag, op, a, b, bus.res_data, exp, lat);
        @(negedge clk);
        check_eq({tag, "_valid_drop"}, 32'(bus.res_valid), 32'd0);
        check_eq({tag, "_ready_back"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.res_ready = 1'b0;

        // Reset state
        #3;
        check_eq("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check_eq("rst_res_data", bus.res_data, 32'd0);
        check_eq("rst_alu_a", bus.alu_a, 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Add, inc, dec with wrap, multiply
        run_op("add", 3'b000, 32'h86, 32'h78, 32'h0000_00FE, ADD_WAIT);
        run_op("inc", 3'b001, 32'h86, 32'h0, 32'h0000_0087, ADD_WAIT);
        run_op("dec", 3'b011, 32'h0, 32'h0, 32'hFFFF_FFFF, ADD_WAIT);
        run_op("mul", 3'b100, 32'h86, 32'h78, 32'h0000_3ED0, MUL_WAIT);

        // Backpressure: hold the result 5 cycles, with an ignored second command.
        @(negedge clk);
        bus.res_ready = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'b010;
        bus.cmd_a     = 32'h86;
        bus.cmd_b     = 32'h78;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check_eq("bp_early_valid", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_res_valid", 32'(bus.res_valid), 32'd1);
            check_eq("bp_res_data", bus.res_data, 32'h0000_000E);
            check_eq("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            check_eq("bp_alu_a_held", bus.alu_a, 32'h86);
            bus.cmd_valid = (i == 1 || i == 2);
            bus.cmd_op    = 3'b000;
            bus.cmd_a     = 32'h1;
            bus.cmd_b     = 32'h1;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        check_eq("bp_ignored_cmd", bus.alu_a, 32'h86);
        check_eq("bp_res_op", 32'(bus.res_op), 32'd2);
        $display("op backpressure: op=010 res=0x%08h held 5 cycles", bus.res_data);
        bus.res_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_valid_drop", 32'(bus.res_valid), 32'd0);
        check_eq("bp_ready_back", 32'(bus.cmd_ready), 32'd1);

        // Reset in the second SETTLE cycle of a multiply discards the op.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'b100;
        bus.cmd_a     = 32'h5;
        bus.cmd_b     = 32'h7;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
        check_eq("mid_rst_res_data", bus.res_data, 32'd0);
        check_eq("mid_rst_res_op", 32'(bus.res_op), 32'd0);
        check_eq("mid_rst_alu_a", bus.alu_a, 32'd0);
        check_eq("mid_rst_alu_b", bus.alu_b, 32'd0);
        check_eq("mid_rst_alu_s", 32'({bus.alu_s2, bus.alu_s1, bus.alu_s0}), 32'd0);
        check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
`ifdef ALU_SEQ_OP_COUNT_EN
        check_eq("mid_rst_op_count", 32'(op_count), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
            check_eq("post_rst_no_valid", 32'(bus.res_valid), 32'd0);
        end
        $display("op reset_mid_op: in-flight multiply discarded");

`ifdef ALU_SEQ_OP_COUNT_EN
        // Four handshakes count to 4; a forced 0xFFFF wraps to 0.
        run_op("cnt0", 3'b000, 32'h1, 32'h2, 32'h3, ADD_WAIT);
        run_op("cnt1", 3'b001, 32'h1, 32'h0, 32'h2, ADD_WAIT);
        run_op("cnt2", 3'b010, 32'h5, 32'h3, 32'h2, ADD_WAIT);
        run_op("cnt3", 3'b100, 32'h3, 32'h4, 32'hC, MUL_WAIT);
        check_eq("op_count_4", 32'(op_count), 32'd4);
        force dut.r_op_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_op_count;
        check_eq("op_count_preload", 32'(op_count), 32'h0000_FFFF);
        run_op("cntw", 3'b000, 32'h1, 32'h1, 32'h2, ADD_WAIT);
        check_eq("op_count_wrap", 32'(op_count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
